// File: rtl/queue_pop_agent.sv
// rtl/queue_pop_agent.sv - read-side pop agent for a 4-entry select-pop queue
module queue_pop_agent #(
    parameter int DATA_W = 6,
    parameter int DEPTH  = 4,
    parameter int OCC_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [DEPTH-1:0]  req_sel,
    output logic              req_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              err,
    input  logic              q_push,
    input  logic              q_full,
    input  logic              q_empty,
    input  logic [DATA_W-1:0] q_data_out,
    output logic              q_pop,
    output logic [DEPTH-1:0]  q_rd_sel,
    output logic [OCC_W-1:0]  occ
);

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

    state_t              state_q;
    logic                req_ready_q;
    logic                out_valid_q;
    logic [DATA_W-1:0]   out_data_q;
    logic                err_q;
    logic                q_pop_q;
    logic [DEPTH-1:0]    q_rd_sel_q;
    logic [OCC_W-1:0]    occ_q;
    logic [OCC_W-1:0]    occ_d;

    logic                sel_onehot;
    logic [OCC_W-1:0]    sel_idx;
    logic                req_ok;
    logic                push_acc;
    logic                pop_acc;

    // Request validation: exactly one bit set, position inside tracked occupancy, queue not empty
    always_comb begin
        sel_onehot = (req_sel != '0) && ((req_sel & (req_sel - DEPTH'(1))) == '0);
        sel_idx    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (req_sel[i]) begin
                sel_idx = OCC_W'(i);
            end
        end
        req_ok = sel_onehot && (sel_idx < occ_q) && !q_empty;
    end

    // Occupancy next-state: a push is accepted when not full or when a pop frees a slot this cycle
    always_comb begin
        push_acc = q_push & (~q_full | q_pop_q);
        pop_acc  = q_pop_q & ~q_empty;
        occ_d    = occ_q;
        if (push_acc && !pop_acc && (occ_q != OCC_W'(DEPTH))) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (pop_acc && !push_acc && (occ_q != '0)) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    // Occupancy tracker register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    // Control FSM with registered outputs; the pop select doubles as the latched request position
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            err_q       <= 1'b0;
            q_pop_q     <= 1'b0;
            q_rd_sel_q  <= '0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        if (req_ok) begin
                            q_pop_q     <= 1'b1;
                            q_rd_sel_q  <= req_sel;
                            req_ready_q <= 1'b0;
                            state_q     <= ISSUE;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    q_pop_q     <= 1'b0;
                    q_rd_sel_q  <= '0;
                    out_data_q  <= q_data_out;
                    out_valid_q <= 1'b1;
                    state_q     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    q_pop_q     <= 1'b0;
                    q_rd_sel_q  <= '0;
                    out_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign err       = err_q;
    assign q_pop     = q_pop_q;
    assign q_rd_sel  = q_rd_sel_q;
    assign occ       = occ_q;

endmodule
